riscv_mem_arbiter: RTL and testbench

Arbitrates one single-port, fixed-latency unified memory between the instruction-fetch stage and the data (load/store) path of the RISC-V pipeline. One transaction is in flight at a time, and a new grant may issue in the cycle the previous one completes. Data accesses have priority. A streak counter guarantees fetch forward progress. The block drives the fetch stage's bubble input and drops fetch responses killed by a branch redirect.

---
 rtl/riscv_mem_arbiter_pkg.sv | 15 +
 rtl/riscv_mem_tracker.sv | 64 ++++++
 rtl/riscv_mem_arbiter.sv | 110 +++++++++++
 tb/tb_riscv_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the fetch/data unified-memory arbiter.
// Owner encodings and counter widths used by the top and the tracker.
// No logic; types and constants only.
package riscv_mem_arbiter_pkg;

    localparam int CNT_W    = 3;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/riscv_mem_tracker.sv
// Tracks the single in-flight memory transaction: owner, latency count, fetch kill flag.
// Latency: state updates one cycle after grant; free/complete are combinational from state.
// Backpressure: none; grants are only issued while free, so one transaction is in flight.
module riscv_mem_tracker
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   grant_if,
    input  logic   grant_d,
    input  logic   if_kill,
    output owner_t owner,
    output logic   free,
    output logic   complete,
    output logic   kill
);

    logic [CNT_W-1:0] cnt, cnt_next;
    owner_t           owner_next;
    logic             kill_next;

    assign complete = (owner != OWNER_NONE) && (cnt == CNT_W'(1));
    assign free     = (owner == OWNER_NONE) || (cnt == CNT_W'(1));

    // State register: owner, latency countdown and kill flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWNER_NONE;
            cnt   <= '0;
            kill  <= 1'b0;
        end else begin
            owner <= owner_next;
            cnt   <= cnt_next;
            kill  <= kill_next;
        end
    end

    // Next state: a new grant reloads, completion idles, otherwise count down.
    always_comb begin
        owner_next = owner;
        cnt_next   = cnt;
        kill_next  = kill;
        if (grant_if || grant_d) begin
            owner_next = grant_d ? OWNER_D : OWNER_IF;
            cnt_next   = CNT_W'(LATENCY);
        end else if (complete) begin
            owner_next = OWNER_NONE;
            cnt_next   = '0;
        end else if (owner != OWNER_NONE) begin
            cnt_next   = cnt - CNT_W'(1);
        end
        // Kill belongs to one fetch: it dies with that fetch's completion,
        // and a redirect in a fresh fetch's grant cycle marks the new one.
        if (complete)
            kill_next = 1'b0;
        if (if_kill && owner == OWNER_IF && !complete)
            kill_next = 1'b1;
        if (if_kill && grant_if)
            kill_next = 1'b1;
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one fixed-latency unified memory between instruction fetch and load/store.
// Latency: grant is combinational; rvalid follows grant by LATENCY cycles, back-to-back issue.
// Backpressure: data wins ties; a streak limit forces a fetch grant; losers see gnt low / if_stall.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    owner_t              owner;
    logic                free, complete, kill;
    logic                grant_if, grant_d;
    logic [STREAK_W-1:0] streak;

    riscv_mem_tracker #(.LATENCY(LATENCY)) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .grant_if (grant_if),
        .grant_d  (grant_d),
        .if_kill  (if_kill),
        .owner    (owner),
        .free     (free),
        .complete (complete),
        .kill     (kill)
    );

    // Arbitration: data first unless the fetch has waited MAX_STREAK data grants.
    // Held off while rst is high so every grant-derived output is 0 in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst && free) begin
            if (d_req && if_req) begin
                if (streak == STREAK_W'(MAX_STREAK))
                    grant_if = 1'b1;
                else
                    grant_d  = 1'b1;
            end else if (d_req) begin
                grant_d  = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Memory command mux: winner's fields, fetch is always a full read.
    always_comb begin
        mem_req   = grant_if || grant_d;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (grant_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
    end

    // Streak of data grants taken while fetch was waiting; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_d && if_req) begin
            if (streak != STREAK_W'(MAX_STREAK))
                streak <= streak + STREAK_W'(1);
        end else if (grant_d || grant_if) begin
            streak <= '0;
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign if_stall  = if_req && !grant_if;

    // A redirect drops the fetch response, whether flagged earlier or arriving now.
    assign if_rvalid = complete && (owner == OWNER_IF) && !kill && !if_kill;
    assign d_rvalid  = complete && (owner == OWNER_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with LATENCY=2, MAX_STREAK=3.
// Inputs change 1ns after the rising edge, outputs are checked 4ns after it.
// Each step is one clock cycle; expected values are hand-computed per scenario.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_mem_arbiter #(.LATENCY(2), .MAX_STREAK(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move from the drive point to the sampling point of the same cycle.
    task automatic settle();
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " if_gnt"},    {31'b0, if_gnt},    32'h0);
        chk({tag, " d_gnt"},     {31'b0, d_gnt},     32'h0);
        chk({tag, " mem_req"},   {31'b0, mem_req},   32'h0);
        chk({tag, " mem_we"},    {31'b0, mem_we},    32'h0);
        chk({tag, " mem_addr"},  mem_addr,           32'h0);
        chk({tag, " mem_wdata"}, mem_wdata,          32'h0);
        chk({tag, " mem_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
        chk({tag, " if_rvalid"}, {31'b0, if_rvalid}, 32'h0);
        chk({tag, " d_rvalid"},  {31'b0, d_rvalid},  32'h0);
        chk({tag, " if_rdata"},  if_rdata,           32'h0);
        chk({tag, " d_rdata"},   d_rdata,            32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_kill   = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = 32'h1234_5678;

        // Reset: outputs quiet, if_stall tracks if_req, no grant in reset
        #2;
        check_all_zero("rst");
        chk("rst if_stall lo", {31'b0, if_stall}, 32'h0);
        if_req = 1'b1;
        #1;
        chk("rst if_stall hi", {31'b0, if_stall}, 32'h1);
        chk("rst if_gnt", {31'b0, if_gnt}, 32'h0);
        if_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mem_rdata = '0;

        // Fetch only: grants T0/T2, rvalid T2/T4
        tick();
        if_req = 1'b1; if_addr = 32'h0;
        settle();
        chk("f T0 if_gnt",   {31'b0, if_gnt},   32'h1);
        chk("f T0 mem_req",  {31'b0, mem_req},  32'h1);
        chk("f T0 mem_addr", mem_addr,          32'h0);
        chk("f T0 mem_we",   {31'b0, mem_we},   32'h0);
        chk("f T0 if_stall", {31'b0, if_stall}, 32'h0);
        tick();
        if_req = 1'b0;
        settle();
        chk("f T1 mem_req",  {31'b0, mem_req},   32'h0);
        chk("f T1 if_rvalid",{31'b0, if_rvalid}, 32'h0);
        chk("f T1 if_stall", {31'b0, if_stall},  32'h0);
        tick();
        if_req = 1'b1; if_addr = 32'h4; mem_rdata = 32'hA000_0000;
        settle();
        chk("f T2 if_rvalid",{31'b0, if_rvalid}, 32'h1);
        chk("f T2 if_rdata", if_rdata,           32'hA000_0000);
        chk("f T2 if_gnt",   {31'b0, if_gnt},    32'h1);
        chk("f T2 mem_addr", mem_addr,           32'h4);
        chk("f T2 mem_we",   {31'b0, mem_we},    32'h0);
        chk("f T2 if_stall", {31'b0, if_stall},  32'h0);
        tick();
        if_req = 1'b0;
        settle();
        chk("f T3 if_rvalid",{31'b0, if_rvalid}, 32'h0);
        tick();
        mem_rdata = 32'hA000_0004;
        settle();
        chk("f T4 if_rvalid",{31'b0, if_rvalid}, 32'h1);
        chk("f T4 if_rdata", if_rdata,           32'hA000_0004);

        // Load and fetch together: data first, fetch at T2
        tick();
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        settle();
        chk("lf T0 d_gnt",    {31'b0, d_gnt},    32'h1);
        chk("lf T0 if_gnt",   {31'b0, if_gnt},   32'h0);
        chk("lf T0 if_stall", {31'b0, if_stall}, 32'h1);
        chk("lf T0 mem_addr", mem_addr,          32'h100);
        tick();
        d_req = 1'b0;
        settle();
        chk("lf T1 if_stall", {31'b0, if_stall}, 32'h1);
        chk("lf T1 mem_req",  {31'b0, mem_req},  32'h0);
        tick();
        mem_rdata = 32'hD00D_0100;
        settle();
        chk("lf T2 d_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("lf T2 d_rdata",  d_rdata,           32'hD00D_0100);
        chk("lf T2 if_gnt",   {31'b0, if_gnt},   32'h1);
        chk("lf T2 mem_addr", mem_addr,          32'h8);
        chk("lf T2 if_stall", {31'b0, if_stall}, 32'h0);
        tick();
        if_req = 1'b0;
        settle();
        tick();
        mem_rdata = 32'hF00D_0008;
        settle();
        chk("lf T4 if_rvalid",{31'b0, if_rvalid}, 32'h1);
        chk("lf T4 if_rdata", if_rdata,           32'hF00D_0008);
        chk("lf T4 d_rvalid", {31'b0, d_rvalid},  32'h0);

        // Streak: both held for five grants, order D D D IF D
        tick();
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        settle();
        chk("s G0 d_gnt",  {31'b0, d_gnt},  32'h1);
        chk("s G0 if_gnt", {31'b0, if_gnt}, 32'h0);
        tick(); settle();
        chk("s G0+1 mem_req", {31'b0, mem_req}, 32'h0);
        tick(); settle();
        chk("s G1 d_gnt",  {31'b0, d_gnt},  32'h1);
        chk("s G1 if_gnt", {31'b0, if_gnt}, 32'h0);
        tick(); tick(); settle();
        chk("s G2 d_gnt",  {31'b0, d_gnt},  32'h1);
        chk("s G2 if_gnt", {31'b0, if_gnt}, 32'h0);
        tick(); tick(); settle();
        chk("s G3 d_gnt",    {31'b0, d_gnt},    32'h0);
        chk("s G3 if_gnt",   {31'b0, if_gnt},   32'h1);
        chk("s G3 mem_addr", mem_addr,          32'h10);
        chk("s G3 d_rvalid", {31'b0, d_rvalid}, 32'h1);
        tick();
        if_addr = 32'h14;
        settle();
        tick(); settle();
        chk("s G4 d_gnt",  {31'b0, d_gnt},  32'h1);
        chk("s G4 if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("s G4 if_rvalid", {31'b0, if_rvalid}, 32'h1);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        settle();
        tick(); settle();
        chk("s end d_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("s end mem_req",  {31'b0, mem_req},  32'h0);

        // Kill at T1: response dropped, next fetch issues at T2
        tick();
        if_req = 1'b1; if_addr = 32'h20;
        settle();
        chk("k T0 if_gnt", {31'b0, if_gnt}, 32'h1);
        tick();
        if_kill = 1'b1; if_addr = 32'h40;
        settle();
        chk("k T1 if_gnt", {31'b0, if_gnt}, 32'h0);
        tick();
        if_kill = 1'b0; mem_rdata = 32'hBAD0_0020;
        settle();
        chk("k T2 if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("k T2 if_rdata",  if_rdata,           32'h0);
        chk("k T2 if_gnt",    {31'b0, if_gnt},    32'h1);
        chk("k T2 mem_addr",  mem_addr,           32'h40);
        tick();
        if_req = 1'b0;
        settle();
        tick();
        mem_rdata = 32'h600D_0040;
        settle();
        chk("k T4 if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("k T4 if_rdata",  if_rdata,           32'h600D_0040);

        // Store: strobes and data pass through, ack two cycles later
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
        d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        settle();
        chk("st T0 d_gnt",     {31'b0, d_gnt},    32'h1);
        chk("st T0 mem_we",    {31'b0, mem_we},   32'h1);
        chk("st T0 mem_wstrb", {28'b0, mem_wstrb},32'h3);
        chk("st T0 mem_wdata", mem_wdata,         32'hDEADBEEF);
        chk("st T0 mem_addr",  mem_addr,          32'h300);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0; d_wdata = '0;
        settle();
        chk("st T1 d_rvalid", {31'b0, d_rvalid}, 32'h0);
        tick(); settle();
        chk("st T2 d_rvalid", {31'b0, d_rvalid}, 32'h1);

        // Reset mid-load: outputs drop at once, no response after release
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        settle();
        chk("r T0 d_gnt", {31'b0, d_gnt}, 32'h1);
        tick();
        d_req = 1'b0; mem_rdata = 32'hEEEE_EEEE;
        #1;
        rst = 1'b1;
        if_req = 1'b1;
        #1;
        check_all_zero("r T1");
        chk("r T1 if_stall", {31'b0, if_stall}, 32'h1);
        tick();
        if_req = 1'b0;
        settle();
        check_all_zero("r T2");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("r post d_rvalid", {31'b0, d_rvalid}, 32'h0);
            chk("r post mem_req",  {31'b0, mem_req},  32'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
